// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and default widths for the register-file read arbiter.
package regfile_read_arbiter_pkg;

    localparam int unsigned DEF_BUS_WIDTH = 32;
    localparam int unsigned DEF_SEL       = 5;
    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_PTR_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_read_arbiter_rr_priority_picker.sv
// Circular first-set-bit search starting at ptr; combinational.
module rr_priority_picker #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] k
);

    localparam int unsigned IW = PTR_W + 1;

    always_comb begin : pick
        logic [IW-1:0] idx;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        // ptr < NREQ, so one conditional subtract wraps the sum back into range
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (!found && mask[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                k     = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sequencer sharing one register-file read port among NREQ readers.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int unsigned SEL       = DEF_SEL,
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned PTR_W     = DEF_PTR_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*SEL-1:0]  Addr,
    input  logic [BUS_WIDTH-1:0] MuxDout,
    output logic [SEL-1:0]       MuxSel,
    output logic [NREQ-1:0]      Ack,
    output logic [BUS_WIDTH-1:0] RdData,
    output logic                 Busy
);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     k_q, k_d;
    logic [SEL-1:0]       sel_d;
    logic [NREQ-1:0]      ack_d;
    logic [BUS_WIDTH-1:0] rd_data_d;
    logic                 busy_d;
    logic [NREQ-1:0]      cand;
    logic [NREQ-1:0]      k_onehot;
    logic                 found;
    logic [PTR_W-1:0]     pick;
    logic [SEL-1:0]       addr_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
        assign addr_arr[gi] = Addr[gi*SEL +: SEL];
    end

    assign k_onehot = NREQ'(1) << k_q;

    // The requester just acknowledged may not win again in its own Ack cycle
    always_comb begin
        cand = Req;
        if (state_q == ST_RESP) begin
            cand = Req & ~k_onehot;
        end
    end

    rr_priority_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .mask  (cand),
        .ptr   (ptr_q),
        .found (found),
        .k     (pick)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (found) state_d = ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: state_d = found ? ST_READ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        ptr_d     = ptr_q;
        k_d       = k_q;
        sel_d     = MuxSel;
        ack_d     = '0;
        rd_data_d = RdData;
        if ((state_q == ST_IDLE || state_q == ST_RESP) && found) begin
            k_d   = pick;
            sel_d = addr_arr[pick];
            ptr_d = (pick == PTR_W'(NREQ - 1)) ? '0 : pick + PTR_W'(1);
        end
        if (state_q == ST_READ) begin
            rd_data_d = MuxDout;
            ack_d     = k_onehot;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q  <= '0;
            k_q    <= '0;
            MuxSel <= '0;
            Ack    <= '0;
            RdData <= '0;
            Busy   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            k_q    <= k_d;
            MuxSel <= sel_d;
            Ack    <= ack_d;
            RdData <= rd_data_d;
            Busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter with a behavioural 32:1 read mux.
module tb_regfile_read_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned NR = 4;
    localparam int unsigned PW = 2;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [BW-1:0] data;
    } exp_t;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [NR-1:0]  Req;
    logic [NR*SW-1:0] Addr;
    logic [BW-1:0]  MuxDout;
    logic [SW-1:0]  MuxSel;
    logic [NR-1:0]  Ack;
    logic [BW-1:0]  RdData;
    logic           Busy;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [NR-1:0] hold = '0;

    regfile_read_arbiter #(
        .BUS_WIDTH (BW),
        .SEL       (SW),
        .NREQ      (NR),
        .PTR_W     (PW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .Addr    (Addr),
        .MuxDout (MuxDout),
        .MuxSel  (MuxSel),
        .Ack     (Ack),
        .RdData  (RdData),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    // Register file contents: reg7 is the marker word, others encode their index
    function automatic logic [BW-1:0] reg_val(input logic [SW-1:0] a);
        return (a == 5'd7) ? 32'hDEADBEEF : {8'hA5, 8'h00, 3'b000, a, 3'b000, a};
    endfunction

    assign MuxDout = reg_val(MuxSel);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge; requesters not in hold drop Req on their Ack
    task automatic cyc();
        @(negedge Clk);
        Req = Req & ~(Ack & ~hold);
    endtask

    task automatic set_addr(input int r, input logic [SW-1:0] a);
        Addr[r*SW +: SW] = a;
    endtask

    task automatic expect_rd(input int r, input logic [SW-1:0] a);
        exp_t e;
        e.ack  = 4'b0001 << r;
        e.data = reg_val(a);
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && (sb.size() != 0 || Busy); i++) begin
            cyc();
        end
        chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
        chk({nm, "_busy"}, 32'(Busy), 32'd0);
        sb.delete();
    endtask

    // Monitor: every Ack cycle must match the oldest expected response
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Ack != '0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got %b data %h expected none", Ack, RdData);
                end else begin
                    e = sb.pop_front();
                    chk("ack", 32'(Ack), 32'(e.ack));
                    chk("rddata", RdData, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int acks;
        Reset = 1'b1;
        Req   = '0;
        Addr  = '0;
        cyc();
        cyc();
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst_rddata", RdData, 32'd0);
        chk("rst_muxsel", 32'(MuxSel), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;

        // Single request, two-cycle latency
        set_addr(0, 5'd7);
        expect_rd(0, 5'd7);
        Req = 4'b0001;
        cyc();
        chk("t1_busy_read", 32'(Busy), 32'd1);
        chk("t1_muxsel", 32'(MuxSel), 32'd7);
        chk("t1_no_ack_yet", 32'(Ack), 32'd0);
        cyc();
        chk("t1_ack_latency", 32'(Ack), 32'b0001);
        chk("t1_data", RdData, 32'hDEADBEEF);
        cyc();
        chk("t1_idle_busy", 32'(Busy), 32'd0);
        chk("t1_idle_ack", 32'(Ack), 32'd0);
        drain("t1");

        // All four held continuously: 0,1,2,3,0,... one Ack every two cycles
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int r = 0; r < 4; r++) set_addr(r, SW'(r + 1));
        for (int n = 0; n < 8; n++) expect_rd(n % 4, SW'(n % 4 + 1));
        hold = 4'b1111;
        Req  = 4'b1111;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (Ack != '0) acks++;
        end
        chk("t2_acks_per_16", 32'(acks), 32'd8);
        hold = '0;
        Req  = '0;
        drain("t2");

        // Fairness: pointer left at 2, Req=1011 -> 3, 0, 1
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        set_addr(1, 5'd5);
        expect_rd(1, 5'd5);
        Req = 4'b0010;
        drain("t3_setup");
        set_addr(0, 5'd10);
        set_addr(1, 5'd11);
        set_addr(2, 5'd12);
        set_addr(3, 5'd13);
        expect_rd(3, 5'd13);
        expect_rd(0, 5'd10);
        expect_rd(1, 5'd11);
        Req = 4'b1011;
        drain("t3");

        // Reset during READ drops the transaction and clears the pointer
        set_addr(2, 5'd20);
        set_addr(3, 5'd21);
        Req = 4'b0100;
        cyc();
        chk("t4_in_read", 32'(Busy), 32'd1);
        chk("t4_muxsel", 32'(MuxSel), 32'd20);
        Reset = 1'b1;
        cyc();
        chk("t4_rst_ack", 32'(Ack), 32'd0);
        chk("t4_rst_rddata", RdData, 32'd0);
        chk("t4_rst_muxsel", 32'(MuxSel), 32'd0);
        chk("t4_rst_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        Req   = Req | 4'b1000;
        expect_rd(2, 5'd20);
        expect_rd(3, 5'd21);
        drain("t4");

        // Addr changed after grant is ignored
        set_addr(1, 5'd3);
        expect_rd(1, 5'd3);
        Req = 4'b0010;
        cyc();
        chk("t5_muxsel", 32'(MuxSel), 32'd3);
        set_addr(1, 5'd9);
        cyc();
        chk("t5_ack", 32'(Ack), 32'b0010);
        chk("t5_data", RdData, 32'hA5000303);
        drain("t5");

        // Requester 0 re-requests in its Ack cycle: 2 goes first, then 0
        set_addr(0, 5'd14);
        set_addr(2, 5'd15);
        expect_rd(0, 5'd14);
        expect_rd(2, 5'd15);
        expect_rd(0, 5'd14);
        hold = 4'b0001;
        Req  = 4'b0001;
        cyc();
        cyc();
        chk("t6_first_ack", 32'(Ack), 32'b0001);
        Req  = 4'b0101;
        hold = '0;
        cyc();
        chk("t6_no_double_ack", 32'(Ack), 32'd0);
        chk("t6_muxsel_req2", 32'(MuxSel), 32'd15);
        drain("t6");

        chk("final_queue", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
